// File: rtl/queen_board_scanner_pkg.sv
// Shared types and limits for the N-Queens board scanner.
package queen_pkg;

  localparam int unsigned MAX_N = 16;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

endpackage

// File: rtl/queen_board_scanner_if.sv
// Start/result bundle between the board scanner and solver control.
interface queen_board_scanner_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned ROW_W = $clog2(N);

  logic                 start;
  logic [N*N-1:0]       board_in;
  logic                 busy;
  logic                 done;
  logic [N*ROW_W-1:0]   rows;
  logic [N-1:0]         col_valid;
  logic                 all_valid;
  logic [ROW_W-1:0]     err_col;
  logic                 conflict;
  logic [ROW_W-1:0]     conflict_col;

  modport master (
    output start, board_in,
    input  busy, done, rows, col_valid, all_valid, err_col, conflict, conflict_col
  );

  modport slave (
    input  start, board_in,
    output busy, done, rows, col_valid, all_valid, err_col, conflict, conflict_col
  );
endinterface

// File: rtl/queen_board_scanner_encoder.sv
// One-hot column word to binary row index; non-one-hot words give row 0.
module onehot_row_encoder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         col,
  output logic [$clog2(N)-1:0] row,
  output logic                 is_onehot
);
  localparam int unsigned ROW_W = $clog2(N);

  always_comb begin
    row       = '0;
    is_onehot = (col != '0) && ((col & (col - 1'b1)) == '0);
    if (is_onehot) begin
      for (int i = 0; i < N; i++) begin
        if (col[i]) row = ROW_W'(i);
      end
    end
  end
endmodule

// File: rtl/queen_board_scanner.sv
// Time-multiplexed N-Queens board scanner: one column per cycle through a shared encoder,
// tracking row/diagonal/anti-diagonal occupancy to flag attacks.
module queen_board_scanner
  import queen_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  queen_board_scanner_if.slave bus
);
  localparam int unsigned ROW_W  = $clog2(N);
  localparam int unsigned IDX_W  = ROW_W + 1;
  localparam int unsigned DIAG_N = 2 * N - 1;

  scan_state_t        state_q, state_d;
  logic [ROW_W-1:0]   col_cnt_q;
  logic [N*N-1:0]     board_q;
  logic [N-1:0]       row_mask_q;
  logic [DIAG_N-1:0]  diag_mask_q, anti_mask_q;
  logic [N*ROW_W-1:0] rows_q;
  logic [N-1:0]       col_valid_q;
  logic               err_seen_q;
  logic [ROW_W-1:0]   err_col_q;
  logic               conflict_q;
  logic [ROW_W-1:0]   conflict_col_q;

  logic               accept;
  logic               last_col;
  logic [N-1:0]       cur_col;
  logic [ROW_W-1:0]   enc_row;
  logic               enc_onehot;
  logic [IDX_W-1:0]   diag_idx, anti_idx;
  logic               hit;

  assign cur_col  = board_q[col_cnt_q*N +: N];
  assign last_col = (col_cnt_q == ROW_W'(N - 1));

  onehot_row_encoder #(.N(N)) u_encoder (
    .col       (cur_col),
    .row       (enc_row),
    .is_onehot (enc_onehot)
  );

  // Add N-1 before subtracting c so the anti-diagonal index never underflows.
  assign diag_idx = IDX_W'(enc_row) + IDX_W'(col_cnt_q);
  assign anti_idx = IDX_W'(enc_row) + IDX_W'(N - 1) - IDX_W'(col_cnt_q);
  assign hit      = row_mask_q[enc_row] | diag_mask_q[diag_idx] | anti_mask_q[anti_idx];

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bus.busy = (state_q == SCAN);
    bus.done = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_col) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      col_cnt_q      <= '0;
      board_q        <= '0;
      row_mask_q     <= '0;
      diag_mask_q    <= '0;
      anti_mask_q    <= '0;
      rows_q         <= '0;
      col_valid_q    <= '0;
      err_seen_q     <= 1'b0;
      err_col_q      <= '0;
      conflict_q     <= 1'b0;
      conflict_col_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        board_q        <= bus.board_in;
        col_cnt_q      <= '0;
        row_mask_q     <= '0;
        diag_mask_q    <= '0;
        anti_mask_q    <= '0;
        rows_q         <= '0;
        col_valid_q    <= '0;
        err_seen_q     <= 1'b0;
        err_col_q      <= '0;
        conflict_q     <= 1'b0;
        conflict_col_q <= '0;
      end else if (state_q == SCAN) begin
        col_cnt_q <= col_cnt_q + 1'b1;
        if (enc_onehot) begin
          rows_q[col_cnt_q*ROW_W +: ROW_W] <= enc_row;
          col_valid_q[col_cnt_q]           <= 1'b1;
          if (hit) begin
            conflict_q <= 1'b1;
            if (!conflict_q) conflict_col_q <= col_cnt_q;
          end
          row_mask_q[enc_row]   <= 1'b1;
          diag_mask_q[diag_idx] <= 1'b1;
          anti_mask_q[anti_idx] <= 1'b1;
        end else if (!err_seen_q) begin
          err_seen_q <= 1'b1;
          err_col_q  <= col_cnt_q;
        end
      end
    end
  end

  assign bus.rows         = rows_q;
  assign bus.col_valid    = col_valid_q;
  assign bus.all_valid    = &col_valid_q;
  assign bus.err_col      = err_col_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_col = conflict_col_q;

endmodule

// File: tb/tb_queen_board_scanner.sv
// Bench for queen_board_scanner at N=8 (per-cycle model compare) and N=4 (directed checks).
module tb_queen_board_scanner;
  import queen_pkg::*;

  typedef struct packed {
    logic [15:0][3:0] row;
    logic [15:0]      cv;
    logic [3:0]       err;
    logic             conf;
    logic [3:0]       ccol;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  queen_board_scanner_if #(.N(8)) b8 ();
  queen_board_scanner_if #(.N(4)) b4 ();

  queen_board_scanner #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  queen_board_scanner #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Placement rules stated directly: pairwise attacks between earlier valid columns.
  function automatic res_t model(input int n, input logic [255:0] b);
    res_t res;
    int   cnt;
    int   dr;
    bit   err_found;
    res = '0;
    err_found = 1'b0;
    for (int c = 0; c < n; c++) begin
      cnt = 0;
      for (int r = 0; r < n; r++) begin
        if (b[c*n+r]) begin
          cnt++;
          res.row[c] = 4'(r);
        end
      end
      if (cnt == 1) begin
        res.cv[c] = 1'b1;
      end else begin
        res.row[c] = '0;
        if (!err_found) begin
          res.err   = 4'(c);
          err_found = 1'b1;
        end
      end
    end
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < c; p++) begin
        if (res.cv[c] && res.cv[p]) begin
          dr = int'(res.row[c]) - int'(res.row[p]);
          if (dr < 0) dr = -dr;
          if (dr == 0 || dr == c - p) begin
            if (!res.conf) res.ccol = 4'(c);
            res.conf = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  // Nibble c of rr is the queen row of column c.
  function automatic logic [255:0] from_rows(input int n, input logic [63:0] rr);
    logic [255:0] b;
    b = '0;
    for (int c = 0; c < n; c++) b[c*n + int'(rr[c*4 +: 4])] = 1'b1;
    return b;
  endfunction

  // N=8 timing model: age counts edges since the accepting edge (0 = never started).
  int   age  = 0;
  res_t exp8 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age  <= 0;
      exp8 <= '0;
    end else if (b8.start && !(age >= 1 && age <= 8)) begin
      age  <= 1;
      exp8 <= model(8, {192'b0, b8.board_in});
    end else if (age != 0 && age <= 9) begin
      age <= age + 1;
    end
  end

  logic [23:0] exp_rows8;
  always @(negedge clk) begin
    chk("busy8", {63'b0, b8.busy}, {63'b0, (age >= 1 && age <= 8)});
    chk("done8", {63'b0, b8.done}, {63'b0, (age == 9)});
    if (!(age >= 1 && age <= 8)) begin
      for (int c = 0; c < 8; c++) exp_rows8[c*3 +: 3] = exp8.row[c][2:0];
      chk("rows8", {40'b0, b8.rows}, {40'b0, exp_rows8});
      chk("col_valid8", {56'b0, b8.col_valid}, {56'b0, exp8.cv[7:0]});
      chk("all_valid8", {63'b0, b8.all_valid}, {63'b0, &exp8.cv[7:0]});
      chk("err_col8", {61'b0, b8.err_col}, {61'b0, exp8.err[2:0]});
      chk("conflict8", {63'b0, b8.conflict}, {63'b0, exp8.conf});
      chk("conflict_col8", {61'b0, b8.conflict_col}, {61'b0, exp8.ccol[2:0]});
    end
  end

  task automatic scan8(input logic [255:0] b, output int lat);
    @(negedge clk);
    #1;
    b8.board_in = b[63:0];
    b8.start    = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (b8.done) break;
    end
  endtask

  task automatic scan4(input logic [255:0] b, output int lat);
    @(negedge clk);
    #1;
    b4.board_in = b[15:0];
    b4.start    = 1'b1;
    @(posedge clk);
    #1;
    b4.start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (b4.done) break;
    end
  endtask

  task automatic check4(input string nm, input logic [255:0] b);
    res_t        e;
    logic [7:0]  er;
    e = model(4, b);
    for (int c = 0; c < 4; c++) er[c*2 +: 2] = e.row[c][1:0];
    chk({nm, "_rows"}, {56'b0, b4.rows}, {56'b0, er});
    chk({nm, "_cv"}, {60'b0, b4.col_valid}, {60'b0, e.cv[3:0]});
    chk({nm, "_conf"}, {63'b0, b4.conflict}, {63'b0, e.conf});
    chk({nm, "_ccol"}, {62'b0, b4.conflict_col}, {62'b0, e.ccol[1:0]});
  endtask

  logic [255:0] sol8;
  logic [255:0] bb;
  int           lat;
  int           ndone;

  initial begin
    b8.start = 1'b0;
    b8.board_in = '0;
    b4.start = 1'b0;
    b4.board_in = '0;
    sol8 = from_rows(8, 64'h31625740);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_done", {63'b0, b8.done}, 64'd0);
    chk("reset_rows", {40'b0, b8.rows}, 64'd0);
    #1 rst_n = 1'b1;

    // Model pins
    chk("model_sol", {63'b0, model(8, sol8).conf}, 64'd0);
    chk("model_diag", {60'b0, model(8, from_rows(8, 64'h31625710)).ccol}, 64'd1);

    // Valid 8-queens solution
    scan8(sol8, lat);
    chk("lat8", lat, 9);
    chk("sol_rows", {40'b0, b8.rows}, 64'h672BE0);
    chk("sol_all_valid", {63'b0, b8.all_valid}, 64'd1);
    chk("sol_conflict", {63'b0, b8.conflict}, 64'd0);
    chk("sol_err_col", {61'b0, b8.err_col}, 64'd0);

    // Columns 0/1 on the same diagonal
    scan8(from_rows(8, 64'h31625710), lat);
    chk("diag_conflict", {63'b0, b8.conflict}, 64'd1);
    chk("diag_ccol", {61'b0, b8.conflict_col}, 64'd1);

    // Empty column 3, double column 5
    bb = sol8;
    bb[24 +: 8] = 8'h00;
    bb[40 +: 8] = 8'h11;
    scan8(bb, lat);
    chk("inv_col_valid", {56'b0, b8.col_valid}, 64'hD7);
    chk("inv_all_valid", {63'b0, b8.all_valid}, 64'd0);
    chk("inv_err_col", {61'b0, b8.err_col}, 64'd3);
    chk("inv_row3", {61'b0, b8.rows[9 +: 3]}, 64'd0);
    chk("inv_row5", {61'b0, b8.rows[15 +: 3]}, 64'd0);
    chk("inv_conflict", {63'b0, b8.conflict}, 64'd0);

    // Reset during scan aborts without a done pulse
    @(negedge clk);
    #1;
    b8.board_in = sol8[63:0];
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'b0, b8.busy}, 64'd0);
    chk("rst_cv", {56'b0, b8.col_valid}, 64'd0);
    #1 rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    scan8(sol8, lat);
    chk("lat8_after_rst", lat, 9);

    // Board change and start pulses during busy are ignored
    @(negedge clk);
    #1;
    b8.board_in = sol8[63:0];
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    @(negedge clk);
    #1;
    bb = from_rows(8, 64'h31625710);
    b8.board_in = bb[63:0];
    b8.start = 1'b1;
    repeat (3) @(negedge clk);
    #1 b8.start = 1'b0;
    lat = 4;
    while (lat < 40 && !b8.done) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_lat", lat, 9);
    chk("mid_rows", {40'b0, b8.rows}, 64'h672BE0);
    chk("mid_conflict", {63'b0, b8.conflict}, 64'd0);

    // start held high: back-to-back scans every N+1 cycles
    @(negedge clk);
    #1;
    b8.board_in = sol8[63:0];
    b8.start = 1'b1;
    ndone = 0;
    repeat (27) begin
      @(negedge clk);
      if (b8.done) ndone++;
    end
    #1 b8.start = 1'b0;
    chk("b2b_dones", ndone, 3);
    repeat (3) @(negedge clk);

    // N=4
    scan4(from_rows(4, 64'h2031), lat);
    chk("lat4", lat, 5);
    chk("n4a_rows", {56'b0, b4.rows}, 64'h8D);
    chk("n4a_all_valid", {63'b0, b4.all_valid}, 64'd1);
    check4("n4a", from_rows(4, 64'h2031));
    scan4(from_rows(4, 64'h1302), lat);
    chk("n4b_conflict", {63'b0, b4.conflict}, 64'd0);
    check4("n4b", from_rows(4, 64'h1302));
    scan4(from_rows(4, 64'h3120), lat);
    chk("n4c_ccol", {62'b0, b4.conflict_col}, 64'd2);
    check4("n4c", from_rows(4, 64'h3120));
    scan4(from_rows(4, 64'h2301), lat);
    chk("n4d_ccol", {62'b0, b4.conflict_col}, 64'd1);
    check4("n4d", from_rows(4, 64'h2301));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
